// File: rtl/line_reader.sv
// line_reader: reads fixed-length lines from a word buffer and streams them to the SLM display.
// Build option: define LINE_READER_PATTERN_EN to replace buffer data with a {line_cnt, word_cnt} test pattern.
// Ports: fpga_clk / reset_all (async, active-high); next_frame_rdy, line_of_data_available and
// num_words_in_buffer report frame and buffer status; buf_rd_en / buf_rd_data form the buffer read port
// (data one cycle after the strobe); slm_data, slm_data_valid, slm_line_start and slm_frame_start form
// the display stream; line_done / frame_done are completion pulses; underflow is a sticky stall flag.
module line_reader #(
  parameter int WORD_WIDTH      = 32,
  parameter int WORDS_PER_LINE  = 64,
  parameter int LINES_PER_FRAME = 1152
) (
  input  logic                  fpga_clk,
  input  logic                  reset_all,
  input  logic                  next_frame_rdy,
  input  logic                  line_of_data_available,
  input  logic [6:0]            num_words_in_buffer,
  output logic                  buf_rd_en,
  input  logic [WORD_WIDTH-1:0] buf_rd_data,
  output logic [WORD_WIDTH-1:0] slm_data,
  output logic                  slm_data_valid,
  output logic                  slm_line_start,
  output logic                  slm_frame_start,
  output logic                  line_done,
  output logic                  frame_done,
  output logic                  underflow
);
  typedef enum logic [1:0] {IDLE, WAIT_LINE, READ, DRAIN} state_t;
  localparam logic [6:0]  LINE_WORDS = 7'(WORDS_PER_LINE);
  localparam logic [6:0]  LAST_WORD  = 7'(WORDS_PER_LINE - 1);
  localparam logic [10:0] LAST_LINE  = 11'(LINES_PER_FRAME - 1);
  state_t                state_q;
  logic [10:0]           line_cnt_q;
  logic [6:0]            word_cnt_q;
  logic                  valid_q, line_start_q, frame_start_q, line_done_q, frame_done_q, underflow_q;
  logic [WORD_WIDTH-1:0] data_q;
  assign buf_rd_en = (state_q == READ) && (num_words_in_buffer != '0);
  always_ff @(posedge fpga_clk or posedge reset_all) begin
    if (reset_all) begin
      state_q       <= IDLE;
      line_cnt_q    <= '0;
      word_cnt_q    <= '0;
      valid_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      line_done_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      valid_q       <= buf_rd_en;
      line_start_q  <= buf_rd_en && (word_cnt_q == '0);
      frame_start_q <= buf_rd_en && (word_cnt_q == '0) && (line_cnt_q == '0);
      line_done_q   <= (state_q == DRAIN);
      frame_done_q  <= (state_q == DRAIN) && (line_cnt_q == LAST_LINE);
      if ((state_q == READ) && (num_words_in_buffer == '0)) underflow_q <= 1'b1;
      case (state_q)
        IDLE: if (next_frame_rdy) begin
          line_cnt_q <= '0;
          state_q    <= WAIT_LINE;
        end
        WAIT_LINE: if (line_of_data_available && (num_words_in_buffer >= LINE_WORDS)) begin
          word_cnt_q <= '0;
          state_q    <= READ;
        end
        READ: if (buf_rd_en) begin
          word_cnt_q <= word_cnt_q + 7'd1;
          if (word_cnt_q == LAST_WORD) state_q <= DRAIN;
        end
        DRAIN: begin
          line_cnt_q <= (line_cnt_q == LAST_LINE) ? '0 : line_cnt_q + 11'd1;
          state_q    <= (line_cnt_q == LAST_LINE) ? IDLE : WAIT_LINE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef LINE_READER_PATTERN_EN
  always_ff @(posedge fpga_clk or posedge reset_all) begin
    if (reset_all) data_q <= '0;
    else if (buf_rd_en) data_q <= WORD_WIDTH'({line_cnt_q, word_cnt_q});
  end
  assign slm_data = data_q;
`else
  // Buffer data lands on the valid cycle itself, so it is passed through then and latched to hold afterwards.
  always_ff @(posedge fpga_clk or posedge reset_all) begin
    if (reset_all) data_q <= '0;
    else if (valid_q) data_q <= buf_rd_data;
  end
  assign slm_data = valid_q ? buf_rd_data : data_q;
`endif
  assign slm_data_valid  = valid_q;
  assign slm_line_start  = line_start_q;
  assign slm_frame_start = frame_start_q;
  assign line_done       = line_done_q;
  assign frame_done      = frame_done_q;
  assign underflow       = underflow_q;
endmodule

// File: tb/tb_line_reader.sv
// tb_line_reader: self-checking bench for line_reader (4 words/line, 2 lines/frame).
module tb_line_reader;
  localparam int W = 32, WPL = 4, LPF = 2;
`ifdef LINE_READER_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif
  typedef struct { logic [W-1:0] d; logic ls; logic fs; } exp_t;
  typedef struct { logic lda; logic [6:0] lvl; logic rd; } vec_t;
  logic fpga_clk = 1'b0, reset_all = 1'b1, next_frame_rdy = 1'b0, line_of_data_available = 1'b0;
  logic [6:0] num_words_in_buffer = '0;
  logic buf_rd_en, slm_data_valid, slm_line_start, slm_frame_start, line_done, frame_done, underflow;
  logic [W-1:0] buf_rd_data = '0;
  logic [W-1:0] slm_data;
  logic [W-1:0] mem [256];
  logic [7:0] rd_ptr = '0;
  logic [7:0] wr_ptr = '0;
  exp_t expq[$];
  vec_t vt [6];
  int vectors = 0, miscompares = 0;

  line_reader #(.WORD_WIDTH(W), .WORDS_PER_LINE(WPL), .LINES_PER_FRAME(LPF)) dut (
    .fpga_clk(fpga_clk), .reset_all(reset_all), .next_frame_rdy(next_frame_rdy),
    .line_of_data_available(line_of_data_available), .num_words_in_buffer(num_words_in_buffer),
    .buf_rd_en(buf_rd_en), .buf_rd_data(buf_rd_data), .slm_data(slm_data),
    .slm_data_valid(slm_data_valid), .slm_line_start(slm_line_start),
    .slm_frame_start(slm_frame_start), .line_done(line_done), .frame_done(frame_done),
    .underflow(underflow)
  );

  always #5 fpga_clk = ~fpga_clk;

  // buffer model: read data appears the cycle after the strobe
  always @(posedge fpga_clk) if (buf_rd_en) begin
    buf_rd_data <= mem[rd_ptr];
    rd_ptr <= rd_ptr + 8'd1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] expw(input int line, input int word, input logic [W-1:0] base);
    logic [W-1:0] p;
    p = W'({11'(line), 7'(word)});
    return PAT ? p : base + W'(word);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_line(input int line, input logic [W-1:0] base);
    for (int i = 0; i < WPL; i++) begin
      mem[wr_ptr] = base + W'(i);
      wr_ptr = wr_ptr + 8'd1;
      expq.push_back('{d: expw(line, i, base), ls: (i == 0), fs: (i == 0) && (line == 0)});
    end
  endtask

  // one clock: scoreboard at the falling edge, return 1 time unit after the rising edge
  task automatic tick();
    exp_t e;
    @(negedge fpga_clk);
    if (slm_data_valid === 1'b1) begin
      if (expq.size() == 0) chk("sb_unexpected_word", 64'(expq.size()), 64'd1);
      else begin
        e = expq.pop_front();
        chk("slm_data", 64'(slm_data), 64'(e.d));
        chk("slm_line_start", 64'(slm_line_start), 64'(e.ls));
        chk("slm_frame_start", 64'(slm_frame_start), 64'(e.fs));
      end
    end else if (!reset_all) chk("start_without_valid", 64'({slm_line_start, slm_frame_start}), 64'd0);
    @(posedge fpga_clk);
    #1;
  endtask

  task automatic wait_line(input string name, input int budget, output logic fd);
    int n;
    n = 0;
    while (line_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(line_done), 64'd1);
    fd = frame_done;
  endtask

  initial begin
    logic fd;
    vt = '{'{1'b0, 7'd10, 1'b0}, '{1'b1, 7'd3, 1'b0}, '{1'b1, 7'd0, 1'b0},
           '{1'b0, 7'd127, 1'b0}, '{1'b1, 7'd3, 1'b0}, '{1'b1, 7'd4, 1'b1}};
    repeat (2) tick();
    chk("rst_buf_rd_en", 64'(buf_rd_en), 64'd0);
    chk("rst_valid", 64'(slm_data_valid), 64'd0);
    chk("rst_slm_data", 64'(slm_data), 64'd0);
    chk("rst_line_done", 64'(line_done), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_underflow", 64'(underflow), 64'd0);
    reset_all = 1'b0;
    tick();
    // line 0: fill-level gating table, then exact read/valid/done timing
    next_frame_rdy = 1'b1;
    tick();
    next_frame_rdy = 1'b0;
    load_line(0, 32'hA0A0_0000);
    foreach (vt[i]) begin
      line_of_data_available = vt[i].lda;
      num_words_in_buffer = vt[i].lvl;
      tick();
      chk("fill_gate_rd_en", 64'(buf_rd_en), 64'(vt[i].rd));
    end
    line_of_data_available = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("l0_rd_en", 64'(buf_rd_en), 64'(k <= 3));
      chk("l0_valid", 64'(slm_data_valid), 64'(k <= 4));
      chk("l0_line_done", 64'(line_done), 64'(k == 5));
    end
    chk("l0_frame_done", 64'(frame_done), 64'd0);
    chk("l0_hold_data", 64'(slm_data), 64'(expw(0, 3, 32'hA0A0_0000)));
    chk("l0_sb_drained", 64'(expq.size()), 64'd0);
    chk("l0_underflow", 64'(underflow), 64'd0);
    num_words_in_buffer = 7'd0;
    // line 1: next_frame_rdy held mid-frame must be ignored; frame_done with line_done
    load_line(1, 32'hB0B0_0000);
    next_frame_rdy = 1'b1;
    line_of_data_available = 1'b1;
    num_words_in_buffer = 7'd8;
    repeat (3) tick();
    next_frame_rdy = 1'b0;
    wait_line("l1_line_done", 20, fd);
    chk("l1_frame_done", 64'(fd), 64'd1);
    chk("l1_sb_drained", 64'(expq.size()), 64'd0);
    tick();
    chk("l1_line_done_pulse", 64'(line_done), 64'd0);
    chk("l1_frame_done_pulse", 64'(frame_done), 64'd0);
    repeat (3) tick();
    chk("idle_no_read", 64'(buf_rd_en), 64'd0);
    // underflow: level drops to 0 after two reads
    line_of_data_available = 1'b0;
    num_words_in_buffer = 7'd0;
    load_line(0, 32'hC0C0_0000);
    next_frame_rdy = 1'b1;
    tick();
    next_frame_rdy = 1'b0;
    line_of_data_available = 1'b1;
    num_words_in_buffer = 7'd4;
    repeat (3) tick();
    chk("uf_before", 64'(underflow), 64'd0);
    num_words_in_buffer = 7'd0;
    #1;
    chk("uf_gap_rd_en", 64'(buf_rd_en), 64'd0);
    tick();
    chk("uf_set", 64'(underflow), 64'd1);
    repeat (2) tick();
    chk("uf_gap_rd_en_held", 64'(buf_rd_en), 64'd0);
    num_words_in_buffer = 7'd3;
    line_of_data_available = 1'b0;
    wait_line("uf_line_done", 20, fd);
    chk("uf_frame_done", 64'(fd), 64'd0);
    chk("uf_sb_drained", 64'(expq.size()), 64'd0);
    chk("uf_sticky", 64'(underflow), 64'd1);
    // reset in the middle of line 1
    load_line(1, 32'hD0D0_0000);
    line_of_data_available = 1'b1;
    num_words_in_buffer = 7'd8;
    repeat (4) tick();
    reset_all = 1'b1;
    #1;
    chk("mid_rst_buf_rd_en", 64'(buf_rd_en), 64'd0);
    chk("mid_rst_valid", 64'(slm_data_valid), 64'd0);
    chk("mid_rst_starts", 64'({slm_line_start, slm_frame_start}), 64'd0);
    chk("mid_rst_dones", 64'({line_done, frame_done}), 64'd0);
    chk("mid_rst_underflow", 64'(underflow), 64'd0);
    chk("mid_rst_slm_data", 64'(slm_data), 64'd0);
    expq.delete();
    wr_ptr = rd_ptr;
    tick();
    reset_all = 1'b0;
    repeat (3) tick();
    chk("post_rst_no_read", 64'(buf_rd_en), 64'd0);
    load_line(0, 32'hE0E0_0000);
    next_frame_rdy = 1'b1;
    tick();
    next_frame_rdy = 1'b0;
    wait_line("post_rst_line_done", 20, fd);
    chk("post_rst_frame_done", 64'(fd), 64'd0);
    chk("sb_empty", 64'(expq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/line_reader.md
LINE_READER -- requirements
Module: line_reader

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, the width of buffer and display data words.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 64, the number of words per display line (legal range 1..127).
REQ-003 SHALL have parameter LINES_PER_FRAME, default 1152, the number of lines per frame (legal range 1..2047).
REQ-004 SHALL have ports:
- fpga_clk  in  1  system clock; all state changes on its rising edge.
- reset_all  in  1  asynchronous, active-high reset.
- next_frame_rdy  in  1  a new frame may begin.
- line_of_data_available  in  1  the buffer holds at least one line.
- num_words_in_buffer  in  7  current buffer fill level.
- buf_rd_en  out  1  buffer read strobe.
- buf_rd_data  in  WORD_WIDTH  buffer read data, valid one cycle after buf_rd_en.
- slm_data  out  WORD_WIDTH  display data word.
- slm_data_valid  out  1  slm_data qualifier.
- slm_line_start  out  1  marks the first word of each line.
- slm_frame_start  out  1  marks the first word of line 0.
- line_done  out  1  one-cycle pulse after the last word of a line.
- frame_done  out  1  one-cycle pulse after the last line of a frame.
- underflow  out  1  sticky stall indicator.

Function
REQ-005 SHALL implement the states IDLE, WAIT_LINE, READ, DRAIN.
REQ-006 In IDLE, next_frame_rdy=1 SHALL clear line_cnt and move to WAIT_LINE; next_frame_rdy SHALL be ignored in every other state.
REQ-007 In WAIT_LINE, line_of_data_available=1 together with num_words_in_buffer >= WORDS_PER_LINE SHALL clear word_cnt and move to READ in the same cycle.
- If line_of_data_available=1 but the fill level is too low, the block SHALL stay in WAIT_LINE.
REQ-008 In READ:
- buf_rd_en = (num_words_in_buffer != 0), combinational from state and fill level.
- word_cnt SHALL increment on each cycle where buf_rd_en=1.
- After the read with word_cnt = WORDS_PER_LINE-1, the block SHALL move to DRAIN.
REQ-009 If num_words_in_buffer == 0 in READ, the block SHALL deassert buf_rd_en, hold word_cnt, and set underflow; reading SHALL resume when the fill level is nonzero.
REQ-010 slm_data_valid SHALL be buf_rd_en delayed by one registered cycle, and slm_data SHALL be registered from buf_rd_data on that cycle.
- slm_data SHALL hold its value when slm_data_valid=0.
REQ-011 Start markers:
- slm_line_start SHALL be 1 exactly on the valid cycle of word 0 of each line.
- slm_frame_start SHALL be 1 on that same cycle only when line_cnt = 0.
REQ-012 DRAIN SHALL last one cycle, and in that cycle:
- the final word is presented;
- line_done pulses on the following cycle;
- line_cnt increments modulo LINES_PER_FRAME.
REQ-013 On leaving DRAIN:
- if the completed line was LINES_PER_FRAME-1, frame_done SHALL pulse coincident with line_done and the block SHALL go to IDLE;
- otherwise the block SHALL go to WAIT_LINE.
REQ-014 Exactly WORDS_PER_LINE slm_data_valid cycles SHALL occur per line, and back-to-back lines SHALL have at least 2 idle cycles between their data.
REQ-015 line_cnt SHALL be 11 bits and word_cnt 7 bits, with no wrap other than the wrap stated in REQ-012.

Reset
REQ-016 Assertion of reset_all SHALL, asynchronously and in any state including mid-line:
- force state to IDLE;
- clear line_cnt and word_cnt;
- drive buf_rd_en, slm_data_valid, slm_line_start, slm_frame_start, line_done, frame_done and underflow to 0;
- drive slm_data to all zeros.
REQ-017 underflow SHALL clear only on reset_all.
REQ-018 After deassertion, the block SHALL wait for a fresh next_frame_rdy; a partial line SHALL NOT resume.

Configuration
REQ-019 With LINE_READER_PATTERN_EN defined:
- slm_data SHALL be {zero-extend, line_cnt[10:0], word_cnt[6:0]} of the word being presented, instead of buf_rd_data;
- buffer reads, handshakes and timing SHALL be unchanged.
REQ-020 Without LINE_READER_PATTERN_EN, slm_data SHALL come from buf_rd_data only, and no pattern logic SHALL be synthesised.

Verification (WORDS_PER_LINE=4, LINES_PER_FRAME=2 unless stated)
REQ-021 Single line:
- Stimulus: next_frame_rdy pulse, then line_of_data_available=1 with level=10 and buffer words A,B,C,D.
- Response: buf_rd_en high 4 cycles; slm_data A..D valid 1 cycle later; slm_line_start and slm_frame_start on A; line_done 1 cycle after D.
REQ-022 Full frame:
- Stimulus: two lines supplied.
- Response: slm_frame_start only on line 0; frame_done coincident with the second line_done; state returns to IDLE; next_frame_rdy is ignored while mid-frame.
REQ-023 Underflow:
- Stimulus: level drops to 0 after 2 reads.
- Response: buf_rd_en low during the gap; underflow=1 and held; all 4 words delivered in order after the level recovers.
REQ-024 Insufficient fill:
- Stimulus: line_of_data_available=1 with level=3.
- Response: no read; block stays in WAIT_LINE until level=4, then reads start.
REQ-025 Reset mid-line:
- Stimulus: reset_all asserted after word 2.
- Response: all outputs 0 immediately; no reads until the next next_frame_rdy; the next line starts with slm_frame_start=1.
REQ-026 Pattern build:
- Stimulus: LINE_READER_PATTERN_EN defined, second line.
- Response: slm_data = 0x80,0x81,0x82,0x83 (line 1, words 0..3).
